tc_program_n: RTL and testbench

TC_PROGRAM_N -- requirements
Module: tc_program_n

---
 rtl/tc_program_n.sv | 102 ++++++++++
 tb/tb_tc_program_n.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tc_program_n.sv
// Loadable program store: a single write path fills DEPTH words in order,
// then PORTS registered read ports serve the program while in RUN.
module tc_program_n #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int PORTS      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS*ADDR_WIDTH-1:0]   address,
   output logic [PORTS*DATA_WIDTH-1:0]   out,
   input  logic                          load_start,
   input  logic                          load_valid,
   input  logic [DATA_WIDTH-1:0]         load_data,
   output logic                          load_ready,
   output logic                          load_done,
   output logic                          busy,
   output logic [1:0]                    state_dbg
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_e;

   state_e                        state_q;
   logic [PW-1:0]                 wptr_q;
   logic                          load_done_q;
   logic [PORTS*DATA_WIDTH-1:0]   out_q;
   logic [DATA_WIDTH-1:0]         mem [DEPTH];

   logic                          beat_accept;
   logic [PORTS-1:0]              rd_ok;
   logic [PW-1:0]                 rd_idx [PORTS];

   // Handshake: a word transfers on a rising edge where load_valid and
   // load_ready are both high; load_start wins and discards that beat.
   assign beat_accept = (state_q == S_LOAD) && load_valid && !load_start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_EMPTY;
         wptr_q      <= '0;
         load_done_q <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         if (load_start) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
         end else if (beat_accept) begin
            if (wptr_q == LAST) begin
               state_q     <= S_RUN;
               wptr_q      <= '0;
               load_done_q <= 1'b1;
            end else begin
               wptr_q <= wptr_q + PW'(1);
            end
         end
      end
   end

   // Storage is deliberately not reset; the RUN gate on reads hides stale words.
   always_ff @(posedge clk) begin
      if (beat_accept) begin
         mem[wptr_q] <= load_data;
      end
   end

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         rd_ok[i]  = ({1'b0, address[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_X);
         rd_idx[i] = address[i*ADDR_WIDTH +: PW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if ((state_q == S_RUN) && rd_ok[i]) begin
               out_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_idx[i]];
            end else begin
               out_q[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end
         end
      end
   end

   assign out        = out_q;
   assign load_ready = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD);
   assign load_done  = load_done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_tc_program_n.sv
// Directed and randomized checks of tc_program_n against a program-level model:
// a completed load makes the loaded words readable, anything else reads zero.
module tb_tc_program_n;

   localparam int DW = 8;
   localparam int AW = 16;
   localparam int DEPTH = 4;
   localparam int PORTS = 2;

   logic                  clk;
   logic                  rst;
   logic [PORTS*AW-1:0]   address;
   logic [PORTS*DW-1:0]   out;
   logic                  load_start;
   logic                  load_valid;
   logic [DW-1:0]         load_data;
   logic                  load_ready;
   logic                  load_done;
   logic                  busy;
   logic [1:0]            state_dbg;

   tc_program_n #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .PORTS(PORTS)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .out(out),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_done(load_done), .busy(busy),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   // Reference model: the last fully loaded program and whether it is readable.
   logic [DW-1:0] prog [DEPTH];
   logic [DW-1:0] words [DEPTH];
   bit            readable = 1'b0;

   always @(negedge clk) if (load_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (readable && (a < AW'(DEPTH))) return prog[a[1:0]];
      return '0;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      address = {a1, a0};
      step();
      check("out0", 32'(out[DW-1:0]), 32'(exp_rd(a0)));
      check("out1", 32'(out[2*DW-1:DW]), 32'(exp_rd(a1)));
   endtask

   // Loads words[]; with_abort first pushes 3 beats and restarts mid-load,
   // offering a beat in the same cycle as load_start.
   task automatic do_load(input int min_gap, input int max_gap, input bit with_abort);
      int start_cnt;
      int gaps;
      start_cnt = done_cnt;
      if (with_abort) begin
         load_start = 1'b1;
         step();
         load_start = 1'b0;
         readable = 1'b0;
         for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = DW'($urandom_range(0, 255));
            step();
         end
         load_valid = 1'b1;
         load_data  = 8'hEE;
      end else begin
         load_valid = 1'b0;
      end
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      load_valid = 1'b0;
      readable   = 1'b0;
      check("ready_after_start", 32'(load_ready), 32'd1);
      check("busy_after_start", 32'(busy), 32'd1);
      for (int j = 0; j < DEPTH; j++) begin
         gaps = $urandom_range(min_gap, max_gap);
         for (int g = 0; g < gaps; g++) begin
            step();
            check("busy_gap", 32'(busy), 32'd1);
            check("out_during_load", 32'(out), 32'd0);
         end
         load_valid = 1'b1;
         load_data  = words[j];
         step();
         load_valid = 1'b0;
         if (j < DEPTH - 1) begin
            check("done_early", 32'(load_done), 32'd0);
            check("busy_beat", 32'(busy), 32'd1);
         end else begin
            check("done_pulse", 32'(load_done), 32'd1);
            check("busy_end", 32'(busy), 32'd0);
            check("ready_end", 32'(load_ready), 32'd0);
         end
      end
      step();
      check("done_single", 32'(load_done), 32'd0);
      check("done_count", 32'(done_cnt - start_cnt), 32'd1);
      for (int j = 0; j < DEPTH; j++) prog[j] = words[j];
      readable = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      address = '0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      #1 rst = 1'b0;
      #1;
      check("rst_out", 32'(out), 32'd0);
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      #20 rst = 1'b1;
      step();
      check("empty_busy", 32'(busy), 32'd0);
      do_read(16'd0, 16'd1);

      // Full load, no gaps.
      words = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_load(0, 0, 1'b0);
      do_read(16'd2, 16'd3);

      // Same words with two-cycle gaps.
      do_load(2, 2, 1'b0);
      do_read(16'd2, 16'd3);
      do_read(16'd0, 16'd1);

      // Boundary addressing.
      do_read(16'd3, 16'd4);
      do_read(16'd0, 16'hFFFF);
      do_read(16'd1, 16'd1);

      // Asynchronous reset mid-cycle while outputs hold data.
      check("pre_rst_out", 32'(out), 32'h2222);
      #1 rst = 1'b0;
      #1;
      readable = 1'b0;
      check("async_out", 32'(out), 32'd0);
      check("async_ready", 32'(load_ready), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      #3 rst = 1'b1;
      do_read(16'd0, 16'd1);

      // Reset during a load abandons it.
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         load_valid = 1'b1;
         load_data  = 8'h5A;
         step();
      end
      load_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      readable = 1'b0;
      check("midload_busy", 32'(busy), 32'd0);
      #2 rst = 1'b1;
      do_read(16'd0, 16'd2);
      words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      do_load(0, 1, 1'b0);
      do_read(16'd0, 16'd3);

      // Restart after three accepted beats.
      words = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_load(0, 1, 1'b1);
      do_read(16'd0, 16'd1);
      do_read(16'd2, 16'd3);

      // Randomized programs and reads.
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < DEPTH; j++) words[j] = DW'($urandom_range(0, 255));
         do_load(0, 2, 1'b0);
         for (int n = 0; n < 8; n++) begin
            logic [AW-1:0] a0;
            logic [AW-1:0] a1;
            a0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : AW'($urandom_range(0, 5));
            a1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : AW'($urandom_range(0, 5));
            do_read(a0, a1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
